mmu_skew_feeder: RTL

//  Parametrised NxN successor to the 2x2 systolic feeder. Latches an NxN weight matrix A
//  and an NxN input matrix B and drives them diagonally skewed into the systolic array
//  (rows of A on a_data, columns of B on b_data). It waits for the array to settle, then

---
 rtl/mmu_skew_feeder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mmu_skew_feeder.sv
// mmu_skew_feeder: NxN systolic feeder. It latches A (weights) and B (inputs),
// drives them into the array with a diagonal skew, waits for the array to
// settle, then streams the N*N results to the host over valid/ready.
// Optional build macro FEEDER_COL_MAJOR_EN: results drain column-major
// instead of row-major. Handshake and timing are identical in both builds.

// One skew lane: shows element (step-LANE) of its operand vector while feeding.
module mmu_skew_lane #(
    parameter int N    = 2,
    parameter int DW   = 8,
    parameter int CNTW = 2,
    parameter int LANE = 0
) (
    input  logic [N-1:0][DW-1:0] vec,
    input  logic [CNTW-1:0]      step,
    input  logic                 feed,
    output logic [DW-1:0]        val
);
    // Lane LANE is delayed by LANE cycles; outside its N-cycle window it shows 0.
    always_comb begin
        val = '0;
        for (int k = 0; k < N; k++)
            if (feed && (int'(step) == LANE + k)) val = vec[k];
    end
endmodule

module mmu_skew_feeder #(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic [N*N*DW-1:0] weight_flat,
    input  logic [N*N*DW-1:0] input_flat,
    input  logic [N*N*CW-1:0] c_flat,
    output logic              clear,
    output logic [N*DW-1:0]   a_data,
    output logic [N*DW-1:0]   b_data,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     host_outdata,
    output logic              done
);
    localparam int CNTW = $clog2(2*N);
    localparam int IDXW = $clog2(N*N);
    localparam int PW   = $clog2(N);

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

    state_t               state, state_nx;
    logic [CNTW-1:0]      cnt;
    logic [IDXW-1:0]      idx;
    logic [PW-1:0]        row, col;
    logic [N*N*DW-1:0]    w_q, x_q;
    logic                 feed, accept, last;
    int                   sel;

    logic [N-1:0][N-1:0][DW-1:0] a_rows, b_cols;
    logic [N-1:0][DW-1:0]        a_lane, b_lane;

    assign accept = out_valid & out_ready;
    assign last   = (idx == IDXW'(N*N-1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state: en low overrides everything and parks the feeder in IDLE.
    always_comb begin
        state_nx = state;
        if (!en) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (start)                     state_nx = FEED;
                FEED:    if (cnt == CNTW'(2*N-2))       state_nx = FLUSH;
                FLUSH:   if (cnt == CNTW'(N-1))         state_nx = DRAIN;
                DRAIN:   if (accept && last)            state_nx = IDLE;
                default:                                state_nx = IDLE;
            endcase
        end
    end

    // State-decoded outputs.
    always_comb begin
        clear     = (state == IDLE);
        busy      = (state != IDLE);
        feed      = (state == FEED);
        out_valid = (state == DRAIN);
    end

    // Step counter restarts on every state change, runs through FEED and FLUSH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                cnt <= '0;
        else if (state != state_nx)             cnt <= '0;
        else if (state == FEED || state == FLUSH) cnt <= cnt + 1'b1;
    end

    // Operands are captured once at start acceptance; later changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q <= '0;
            x_q <= '0;
        end else if (state == IDLE && en && start) begin
            w_q <= weight_flat;
            x_q <= input_flat;
        end
    end

    // Drain pointer: idx counts accepted results, row/col locate the element.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            row <= '0;
            col <= '0;
        end else if (state != DRAIN || !en || (accept && last)) begin
            idx <= '0;
            row <= '0;
            col <= '0;
        end else if (accept) begin
            idx <= idx + 1'b1;
`ifdef FEEDER_COL_MAJOR_EN
            if (row == PW'(N-1)) begin
                row <= '0;
                col <= col + 1'b1;
            end else begin
                row <= row + 1'b1;
            end
`else
            if (col == PW'(N-1)) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
`endif
        end
    end

    // done pulses the cycle after the last result is taken (unless aborted by en).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done <= 1'b0;
        else     done <= en && (state == DRAIN) && accept && last;
    end

    // Result select; forced to 0 whenever nothing is being offered.
    always_comb begin
        sel          = int'(row) * N + int'(col);
        host_outdata = '0;
        if (out_valid)
            for (int e = 0; e < N*N; e++)
                if (sel == e) host_outdata = c_flat[e*CW +: CW];
    end

    // Reshape latched matrices: lane g of A is row g, lane g of B is column g.
    for (genvar g = 0; g < N; g++) begin : g_reshape
        for (genvar k = 0; k < N; k++) begin : g_elem
            assign a_rows[g][k] = w_q[(g*N+k)*DW +: DW];
            assign b_cols[g][k] = x_q[(k*N+g)*DW +: DW];
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        mmu_skew_lane #(.N(N), .DW(DW), .CNTW(CNTW), .LANE(g)) u_a (
            .vec(a_rows[g]), .step(cnt), .feed(feed), .val(a_lane[g])
        );
        mmu_skew_lane #(.N(N), .DW(DW), .CNTW(CNTW), .LANE(g)) u_b (
            .vec(b_cols[g]), .step(cnt), .feed(feed), .val(b_lane[g])
        );
    end

    assign a_data = a_lane;
    assign b_data = b_lane;
endmodule
